// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the front-end pipeline controller: FSM states and PC source selects.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN        = 3'd0,
    ST_BR_WAIT    = 3'd1,
    ST_BR_REDIR   = 3'd2,
    ST_TRAP_DRAIN = 3'd3,
    ST_TRAP_REDIR = 3'd4
  } state_t;

  localparam logic [1:0] PCSEL_SEQ  = 2'd0;
  localparam logic [1:0] PCSEL_BR   = 2'd1;
  localparam logic [1:0] PCSEL_TRAP = 2'd2;

  localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Fetch/decode sequencer: holds fetch on branches and ECALLs until resolution, then redirects the PC.
// Load enables and PC select are combinational from state and inputs; everything else is registered.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        DE_V,
  input  logic        DE_BR_STALL,
  input  logic        DE_TRAP_STALL,
  input  logic        V_HAZARD_STALL,
  input  logic        V_MEM_STALL,
  input  logic        EXE_BR_RESOLVED,
  input  logic [63:0] EXE_BR_NEXT,
  input  logic        WB_CS,
  input  logic [63:0] DE_MTVEC,
  output logic        LD_PC,
  output logic        LD_DE,
  output logic        DE_V_IN,
  output logic [1:0]  PC_SEL,
  output logic [63:0] REDIR_PC,
  output logic [2:0]  CTRL_STATE,
  output logic        TIMEOUT_ERR,
  output logic [31:0] STALL_CYCLES
);

  // Abort fires in the cycle the counter shows TIMEOUT-1, i.e. after TIMEOUT cycles of waiting.
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT - 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_ONE  = WAIT_CNT_W'(1);

  state_t                state;
  state_t                state_nxt;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  in_wait;
  logic                  timed_out;
  logic                  redir_load;
  logic                  err_set;
  logic                  ld_pc_c;
  logic                  ld_de_c;
  logic                  de_v_in_c;
  logic [1:0]            pc_sel_c;

  // The trap vector feeds the PC mux outside this block; it only matters here as the PC_SEL target.
  logic unused_mtvec;
  assign unused_mtvec = ^DE_MTVEC;

  assign in_wait   = (state == ST_BR_WAIT) || (state == ST_TRAP_DRAIN);
  assign timed_out = (wait_cnt == WAIT_LAST);

  always_comb begin
    state_nxt  = state;
    ld_pc_c    = 1'b0;
    ld_de_c    = 1'b0;
    de_v_in_c  = 1'b0;
    pc_sel_c   = PCSEL_SEQ;
    redir_load = 1'b0;
    err_set    = 1'b0;
    case (state)
      ST_RUN: begin
        if (!(V_MEM_STALL || V_HAZARD_STALL)) begin
          if (DE_V && DE_BR_STALL) begin
            ld_de_c   = 1'b1;
            state_nxt = ST_BR_WAIT;
          end else if (DE_V && DE_TRAP_STALL) begin
            ld_de_c   = 1'b1;
            state_nxt = ST_TRAP_DRAIN;
          end else begin
            ld_pc_c   = 1'b1;
            ld_de_c   = 1'b1;
            de_v_in_c = 1'b1;
          end
        end
      end
      ST_BR_WAIT: begin
        ld_de_c = !V_MEM_STALL;
        if (EXE_BR_RESOLVED) begin
          redir_load = 1'b1;
          state_nxt  = ST_BR_REDIR;
        end else if (timed_out) begin
          err_set   = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_BR_REDIR: begin
        pc_sel_c = PCSEL_BR;
        if (!V_MEM_STALL) begin
          ld_pc_c   = 1'b1;
          ld_de_c   = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_TRAP_DRAIN: begin
        ld_de_c = !V_MEM_STALL;
        if (WB_CS) begin
          state_nxt = ST_TRAP_REDIR;
        end else if (timed_out) begin
          err_set   = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_TRAP_REDIR: begin
        pc_sel_c = PCSEL_TRAP;
        if (!V_MEM_STALL) begin
          ld_pc_c   = 1'b1;
          ld_de_c   = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ST_RUN;
      REDIR_PC    <= '0;
      TIMEOUT_ERR <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (redir_load) REDIR_PC <= EXE_BR_NEXT;
      if (err_set) TIMEOUT_ERR <= 1'b1;
      // Zero outside the wait states, so every entry starts counting from 0.
      wait_cnt <= in_wait ? (wait_cnt + WAIT_ONE) : '0;
    end
  end

  assign LD_PC      = ld_pc_c   && !RESET;
  assign LD_DE      = ld_de_c   && !RESET;
  assign DE_V_IN    = de_v_in_c && !RESET;
  assign PC_SEL     = RESET ? PCSEL_SEQ : pc_sel_c;
  assign CTRL_STATE = state;

  sat_counter #(.W(32)) u_stall_cnt (
    .clk   (CLK),
    .clr   (RESET),
    .en    (!LD_PC),
    .count (STALL_CYCLES)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus queues expected per-cycle outputs, a negedge monitor compares.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        de_v, br, trap, haz, mem, res, wbcs;
  logic [63:0] nxt, mtvec;
  logic        ld_pc, ld_de, de_v_in, timeout_err;
  logic [1:0]  pc_sel;
  logic [63:0] redir_pc;
  logic [2:0]  ctrl_state;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  pipe_ctrl #(.TIMEOUT(15)) dut (
    .CLK(clk), .RESET(rst), .DE_V(de_v), .DE_BR_STALL(br), .DE_TRAP_STALL(trap),
    .V_HAZARD_STALL(haz), .V_MEM_STALL(mem), .EXE_BR_RESOLVED(res), .EXE_BR_NEXT(nxt),
    .WB_CS(wbcs), .DE_MTVEC(mtvec), .LD_PC(ld_pc), .LD_DE(ld_de), .DE_V_IN(de_v_in),
    .PC_SEL(pc_sel), .REDIR_PC(redir_pc), .CTRL_STATE(ctrl_state),
    .TIMEOUT_ERR(timeout_err), .STALL_CYCLES(stall_cycles)
  );

  typedef struct {
    string       name;
    logic        ld_pc, ld_de, de_v_in, err;
    logic [1:0]  pc_sel;
    logic [2:0]  st;
    logic [63:0] redir;
    logic [31:0] stall;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic        exp_err = 1'b0;
  logic [63:0] exp_redir = '0;
  logic [31:0] stall_model = '0;

  task automatic chk(input string tag, input string fld, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h", tag, fld, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk(mon_e.name, "LD_PC",        64'(ld_pc),        64'(mon_e.ld_pc));
      chk(mon_e.name, "LD_DE",        64'(ld_de),        64'(mon_e.ld_de));
      chk(mon_e.name, "DE_V_IN",      64'(de_v_in),      64'(mon_e.de_v_in));
      chk(mon_e.name, "PC_SEL",       64'(pc_sel),       64'(mon_e.pc_sel));
      chk(mon_e.name, "CTRL_STATE",   64'(ctrl_state),   64'(mon_e.st));
      chk(mon_e.name, "REDIR_PC",     redir_pc,          mon_e.redir);
      chk(mon_e.name, "TIMEOUT_ERR",  64'(timeout_err),  64'(mon_e.err));
      chk(mon_e.name, "STALL_CYCLES", 64'(stall_cycles), 64'(mon_e.stall));
    end
  end

  task automatic set_in(input logic v, b, t, h, m, r, w);
    de_v = v; br = b; trap = t; haz = h; mem = m; res = r; wbcs = w;
  endtask

  // Queue expectations for the current cycle, then advance to just after the next edge.
  task automatic cyc(input string nm, input logic lp, input logic ld, input logic dv,
                     input logic [1:0] sel, input state_t st);
    exp_t e;
    e.name = nm; e.ld_pc = lp; e.ld_de = ld; e.de_v_in = dv; e.pc_sel = sel;
    e.st = st; e.redir = exp_redir; e.err = exp_err; e.stall = stall_model;
    sb.push_back(e);
    if (rst) stall_model = '0;
    else if (!lp) stall_model = stall_model + 32'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; nxt = '0; mtvec = '0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    cyc("rst0", 0, 0, 0, PCSEL_SEQ, ST_RUN);
    set_in(1, 0, 0, 0, 0, 0, 0);
    cyc("rst1", 0, 0, 0, PCSEL_SEQ, ST_RUN);
    rst = 1'b0;

    repeat (3) cyc("free", 1, 1, 1, PCSEL_SEQ, ST_RUN);

    set_in(1, 1, 0, 0, 0, 0, 0); cyc("br_det", 0, 1, 0, PCSEL_SEQ, ST_RUN);
    set_in(0, 0, 0, 0, 0, 0, 0); cyc("br_w1", 0, 1, 0, PCSEL_SEQ, ST_BR_WAIT);
    set_in(0, 0, 0, 0, 0, 1, 0); nxt = 64'h1000;
    cyc("br_w2", 0, 1, 0, PCSEL_SEQ, ST_BR_WAIT);
    set_in(0, 0, 0, 0, 0, 0, 0); nxt = '0; exp_redir = 64'h1000;
    cyc("br_redir", 1, 1, 0, PCSEL_BR, ST_BR_REDIR);
    set_in(1, 0, 0, 0, 0, 0, 0); cyc("br_run", 1, 1, 1, PCSEL_SEQ, ST_RUN);

    mtvec = 64'h8000_0000;
    set_in(1, 0, 1, 0, 0, 0, 0); cyc("tr_det", 0, 1, 0, PCSEL_SEQ, ST_RUN);
    set_in(0, 0, 0, 0, 0, 1, 0); nxt = 64'hdead;
    cyc("tr_d1", 0, 1, 0, PCSEL_SEQ, ST_TRAP_DRAIN);
    set_in(0, 0, 0, 0, 1, 0, 0); nxt = '0;
    cyc("tr_d2", 0, 0, 0, PCSEL_SEQ, ST_TRAP_DRAIN);
    set_in(0, 0, 0, 0, 0, 0, 1); cyc("tr_d3", 0, 1, 0, PCSEL_SEQ, ST_TRAP_DRAIN);
    set_in(0, 0, 0, 0, 0, 0, 0); cyc("tr_redir", 1, 1, 0, PCSEL_TRAP, ST_TRAP_REDIR);
    set_in(1, 0, 0, 0, 0, 0, 0); cyc("tr_run", 1, 1, 1, PCSEL_SEQ, ST_RUN);

    set_in(1, 1, 0, 1, 0, 0, 0); cyc("frz_haz", 0, 0, 0, PCSEL_SEQ, ST_RUN);
    set_in(1, 0, 1, 0, 1, 0, 0); cyc("frz_mem", 0, 0, 0, PCSEL_SEQ, ST_RUN);

    set_in(1, 1, 1, 0, 0, 0, 0); cyc("pri_det", 0, 1, 0, PCSEL_SEQ, ST_RUN);
    set_in(0, 0, 0, 0, 1, 1, 0); nxt = 64'h2000;
    cyc("pri_w", 0, 0, 0, PCSEL_SEQ, ST_BR_WAIT);
    set_in(0, 0, 0, 0, 1, 0, 0); nxt = '0; exp_redir = 64'h2000;
    repeat (4) cyc("ms_hold", 0, 0, 0, PCSEL_BR, ST_BR_REDIR);
    set_in(0, 0, 0, 0, 0, 0, 0); cyc("ms_go", 1, 1, 0, PCSEL_BR, ST_BR_REDIR);
    set_in(1, 0, 0, 0, 0, 0, 0); cyc("ms_run", 1, 1, 1, PCSEL_SEQ, ST_RUN);

    set_in(1, 1, 0, 0, 0, 0, 0); cyc("to_det", 0, 1, 0, PCSEL_SEQ, ST_RUN);
    set_in(0, 0, 0, 0, 0, 0, 1);
    repeat (15) cyc("to_wait", 0, 1, 0, PCSEL_SEQ, ST_BR_WAIT);
    exp_err = 1'b1;
    set_in(1, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc("to_run", 1, 1, 1, PCSEL_SEQ, ST_RUN);

    set_in(1, 1, 0, 0, 0, 0, 0); cyc("pw_det", 0, 1, 0, PCSEL_SEQ, ST_RUN);
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (14) cyc("pw_wait", 0, 1, 0, PCSEL_SEQ, ST_BR_WAIT);
    set_in(0, 0, 0, 0, 0, 1, 0); nxt = 64'h3000;
    cyc("pw_last", 0, 1, 0, PCSEL_SEQ, ST_BR_WAIT);
    set_in(0, 0, 0, 0, 0, 0, 0); nxt = '0; exp_redir = 64'h3000;
    cyc("pw_redir", 1, 1, 0, PCSEL_BR, ST_BR_REDIR);
    set_in(1, 0, 0, 0, 0, 0, 0); cyc("pw_run", 1, 1, 1, PCSEL_SEQ, ST_RUN);

    set_in(1, 0, 1, 0, 0, 0, 0); cyc("rs_det", 0, 1, 0, PCSEL_SEQ, ST_RUN);
    set_in(0, 0, 0, 0, 0, 0, 0); cyc("rs_d1", 0, 1, 0, PCSEL_SEQ, ST_TRAP_DRAIN);
    rst = 1'b1; cyc("rs_rst", 0, 0, 0, PCSEL_SEQ, ST_TRAP_DRAIN);
    rst = 1'b0; exp_redir = '0; exp_err = 1'b0;
    set_in(1, 0, 0, 0, 0, 0, 0); cyc("rs_after", 1, 1, 1, PCSEL_SEQ, ST_RUN);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
